// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB hue sequencer.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
//   DUTY_W / DUTY_MAX : duty width and full-scale duty value
//   phase_t           : hue wheel sector, PH0..PH5 (codes 6/7 are illegal)
//   rgb_t             : packed red/green/blue duty triple
//   next_phase()      : sector successor; illegal codes map to PH0
//   raw_colour()      : unscaled colour for a sector and ramp level
package rgb_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4,
    PH5 = 3'd5
  } phase_t;

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_t;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH0:     n = PH1;
      PH1:     n = PH2;
      PH2:     n = PH3;
      PH3:     n = PH4;
      PH4:     n = PH5;
      default: n = PH0; // PH5 wraps; codes 6/7 recover here as well
    endcase
    return n;
  endfunction

  // Each sector holds one channel at full scale, ramps a second one up or
  // down with the level, and keeps the third off.
  function automatic rgb_t raw_colour(input phase_t p, input logic [DUTY_W-1:0] l);
    rgb_t c;
    logic [DUTY_W-1:0] inv;
    inv = DUTY_MAX - l;
    case (p)
      PH0:     c = '{r: DUTY_MAX, g: l,        b: 8'd0};
      PH1:     c = '{r: inv,      g: DUTY_MAX, b: 8'd0};
      PH2:     c = '{r: 8'd0,     g: DUTY_MAX, b: l};
      PH3:     c = '{r: 8'd0,     g: inv,      b: DUTY_MAX};
      PH4:     c = '{r: l,        g: 8'd0,     b: DUTY_MAX};
      PH5:     c = '{r: DUTY_MAX, g: 8'd0,     b: inv};
      default: c = '0; // illegal sector: dark until the next tick repairs it
    endcase
    return c;
  endfunction

endpackage

// File: rtl/duty_scale.sv
// Scales one raw channel duty by the global brightness: (raw * (bright+1)) >> 8.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.
//   raw    : unscaled duty 0..255
//   bright : brightness, 255 = identity, 0 = off
//   scaled : scaled duty
module duty_scale
  import rgb_pkg::*;
(
  input  logic [DUTY_W-1:0] raw,
  input  logic [DUTY_W-1:0] bright,
  output logic [DUTY_W-1:0] scaled
);

  logic [8:0]  bright_p1;
  logic [16:0] prod;
  logic        unused_prod_msb;

  // bright+1 needs the ninth bit so that full brightness multiplies by 256
  assign bright_p1 = {1'b0, bright} + 9'd1;
  assign prod      = {9'd0, raw} * {8'd0, bright_p1};
  assign scaled    = prod[15:8];

  // 255 * 256 never reaches bit 16
  assign unused_prod_msb = prod[16];

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Fades RGB PWM duties around the hue wheel, scaled by a global brightness.
// Latency: state -> stage regs 1 cycle; stage -> duty_* on the edge where period_end=1.
// Backpressure: none; duties are only handed over when the PWM stage flags period end.
//   clk, rst_n        : system clock, async active-low reset
//   en                : run prescaler and hue state (0 freezes them)
//   bright            : global brightness 0..255
//   period_end        : last-cycle pulse from the PWM stage
//   duty_r/g/b        : duties presented to the PWM stage
//   duty_upd          : one-cycle pulse, duty_* were loaded at this edge
module rgb_hue_sequencer
  import rgb_pkg::*;
#(
  parameter int STEP_DIV = 390625, // clk cycles per hue step, >= 2
  parameter int STEP     = 1       // level increment per hue step, 1..255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] bright,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              duty_upd
);

  localparam int               CNT_W    = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [8:0]       STEP_9   = 9'(STEP);

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  phase_t            phase;
  logic [DUTY_W-1:0] level;
  logic [8:0]        level_sum;
  logic [DUTY_W-1:0] level_sat;
  rgb_t              raw;
  logic [DUTY_W-1:0] scaled_r, scaled_g, scaled_b;
  rgb_t              stage;

  // ---------------------------------------------------------------- prescaler
  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------- hue state
  // Sum in 9 bits so a large STEP near the top saturates instead of wrapping.
  assign level_sum = {1'b0, level} + STEP_9;
  assign level_sat = level_sum[8] ? DUTY_MAX : level_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH0;
      level <= '0;
    end else if (tick) begin
      // An illegal sector code goes straight to PH0 with the ramp restarted.
      if (level == DUTY_MAX || phase > PH5) begin
        level <= '0;
        phase <= next_phase(phase);
      end else begin
        level <= level_sat;
      end
    end
  end

  // ---------------------------------------------------------------- scaling
  assign raw = raw_colour(phase, level);

  duty_scale u_scale_r (.raw(raw.r), .bright(bright), .scaled(scaled_r));
  duty_scale u_scale_g (.raw(raw.g), .bright(bright), .scaled(scaled_g));
  duty_scale u_scale_b (.raw(raw.b), .bright(bright), .scaled(scaled_b));

  // -------------------------------------------------- stage and output regs
  // The stage always holds the colour from the previous cycle, so a tick
  // landing on the period_end edge hands over the pre-tick colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage    <= '0;
      duty_r   <= '0;
      duty_g   <= '0;
      duty_b   <= '0;
      duty_upd <= 1'b0;
    end else begin
      stage <= '{r: scaled_r, g: scaled_g, b: scaled_b};
      if (period_end) begin
        duty_r   <= stage.r;
        duty_g   <= stage.g;
        duty_b   <= stage.b;
        duty_upd <= 1'b1;
      end else begin
        duty_upd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Randomized self-checking bench for rgb_hue_sequencer (STEP=1 and STEP=100 instances).
// Reference model derives hue sector and level from the count of enabled cycles.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_rgb_hue_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       period_end = 1'b0;
  logic [7:0] bright = 8'd0;

  logic [7:0] d1_r, d1_g, d1_b, d2_r, d2_g, d2_b;
  logic       d1_upd, d2_upd;

  int errors = 0;
  int checks = 0;

  // reference model state
  int steps [2] = '{1, 100};
  int en_cycles;
  int m_stage [2][3];
  int m_duty  [2][3];
  int m_upd;

  always #5 clk = ~clk;

  rgb_hue_sequencer #(.STEP_DIV(DIV), .STEP(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .en(en), .bright(bright), .period_end(period_end),
    .duty_r(d1_r), .duty_g(d1_g), .duty_b(d1_b), .duty_upd(d1_upd)
  );

  rgb_hue_sequencer #(.STEP_DIV(DIV), .STEP(100)) dut_s100 (
    .clk(clk), .rst_n(rst_n), .en(en), .bright(bright), .period_end(period_end),
    .duty_r(d2_r), .duty_g(d2_g), .duty_b(d2_b), .duty_upd(d2_upd)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scale(input int raw, input int b);
    return (raw * (b + 1)) / 256;
  endfunction

  // Colour after t ticks: each sector visits levels 0, s, 2s, ... clipped at
  // 255, one per tick, then moves to the next of six sectors.
  function automatic void colour(input int s, input int t,
                                 output int r, output int g, output int b);
    int tpp, ph, l, nl;
    tpp = (255 + s - 1) / s + 1;
    ph  = (t / tpp) % 6;
    l   = (t % tpp) * s;
    if (l > 255) l = 255;
    nl  = 255 - l;
    case (ph)
      0:       begin r = 255; g = l;   b = 0;   end
      1:       begin r = nl;  g = 255; b = 0;   end
      2:       begin r = 0;   g = 255; b = l;   end
      3:       begin r = 0;   g = nl;  b = 255; end
      4:       begin r = l;   g = 0;   b = 255; end
      default: begin r = 255; g = 0;   b = nl;  end
    endcase
  endfunction

  task automatic model_reset();
    en_cycles = 0;
    m_upd = 0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) begin
        m_stage[k][c] = 0;
        m_duty[k][c]  = 0;
      end
  endtask

  task automatic model_edge();
    int r, g, b;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (period_end)
          for (int c = 0; c < 3; c++) m_duty[k][c] = m_stage[k][c];
        colour(steps[k], en_cycles / DIV, r, g, b);
        m_stage[k][0] = scale(r, int'(bright));
        m_stage[k][1] = scale(g, int'(bright));
        m_stage[k][2] = scale(b, int'(bright));
      end
      m_upd = period_end ? 1 : 0;
      if (en) en_cycles++;
    end
  endtask

  task automatic check_outputs();
    check("s1_r",    d1_r,   m_duty[0][0]);
    check("s1_g",    d1_g,   m_duty[0][1]);
    check("s1_b",    d1_b,   m_duty[0][2]);
    check("s1_upd",  d1_upd, m_upd);
    check("s100_r",  d2_r,   m_duty[1][0]);
    check("s100_g",  d2_g,   m_duty[1][1]);
    check("s100_b",  d2_b,   m_duty[1][2]);
    check("s100_upd", d2_upd, m_upd);
  endtask

  // Called on a falling edge: check, drive the next inputs, clock once.
  task automatic cycle(input logic e, input logic pe, input logic [7:0] br);
    check_outputs();
    en = e;
    period_end = pe;
    bright = br;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_to_tick(input string tag, input int target);
    for (int i = 0; i < 8000 && ((en_cycles / DIV) % 1536) != target; i++)
      cycle(1'b1, 1'b1, 8'd255);
    check(tag, (en_cycles / DIV) % 1536, target);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // reset held for ten cycles
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'd255);
    rst_n = 1'b1;

    // one full wheel plus margin at full brightness, loading every cycle
    for (int i = 0; i < 1536 * DIV + 40; i++) cycle(1'b1, 1'b1, 8'd255);

    // fixed brightness levels, including half and off
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 8'd128);
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 8'd0);
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 8'd255);

    // sparse period_end: one pulse every 16 cycles, random brightness
    for (int i = 0; i < 640; i++)
      cycle(1'b1, (i % 16) == 15, 8'($urandom_range(0, 255)));

    // fully random enable, period_end and brightness
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            8'($urandom_range(0, 255)));

    // freeze mid-PH2 for 100 cycles while loads keep going
    run_to_tick("reach_ph2", 640);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'd255);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'd255);

    // asynchronous reset mid-PH3: outputs clear without waiting for an edge
    run_to_tick("reach_ph3", 900);
    check_outputs();
    #2 rst_n = 1'b0;
    #1;
    check("arst_r",   d1_r,   0);
    check("arst_g",   d1_g,   0);
    check("arst_b",   d1_b,   0);
    check("arst_upd", d1_upd, 0);
    check("arst_r100", d2_r,  0);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'd255);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) cycle(1'b1, 1'b1, 8'd255);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
